// File: rtl/mips_fact.sv
// Memory-mapped factorial accelerator: write N, write GO, poll STATUS, read RESULT.
// One multiply per clock while BUSY; fixed latency of max(n,1)+1 edges from the go write.
module mips_fact (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic [1:0]  a,
    input  logic [31:0] wd,
    output logic [31:0] rd
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;
    localparam logic [3:0] MAX_N       = 4'd12;

    state_t      state_reg;
    logic [3:0]  n_reg;
    logic        go_reg;
    logic        done_reg;
    logic        err_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] prod_reg;
    logic [31:0] result_reg;

    // Only wd[3:0] is ever stored; the upper bits are don't-care.
    logic unused_wd;
    assign unused_wd = ^wd[31:4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            n_reg      <= 4'd0;
            go_reg     <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= 4'd0;
            prod_reg   <= 32'd1;
            result_reg <= 32'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (we && a == ADDR_N) begin
                        n_reg <= wd[3:0];
                    end
                    if (we && a == ADDR_GO && wd[0]) begin
                        cnt_reg  <= n_reg;
                        prod_reg <= 32'd1;
                        if (n_reg > MAX_N) begin
                            // 13! does not fit in 32 bits: flag it and never go busy.
                            err_reg  <= 1'b1;
                            done_reg <= 1'b1;
                        end else begin
                            err_reg   <= 1'b0;
                            done_reg  <= 1'b0;
                            go_reg    <= 1'b1;
                            state_reg <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_reg > 4'd1) begin
                        prod_reg <= prod_reg * {28'd0, cnt_reg};
                        cnt_reg  <= cnt_reg - 4'd1;
                    end else begin
                        result_reg <= prod_reg;
                        done_reg   <= 1'b1;
                        go_reg     <= 1'b0;
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd = 32'd0;
        case (a)
            ADDR_N:      rd = {28'd0, n_reg};
            ADDR_GO:     rd = {31'd0, go_reg};
            ADDR_STATUS: rd = {30'd0, err_reg, done_reg};
            ADDR_RESULT: rd = result_reg;
            default:     rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mips_fact.sv
// Self-checking bench for mips_fact: a job-level reference model checked every
// cycle, plus directed register reads with hand-computed values.
module tb_mips_fact;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    logic [1:0] rot = 2'd0;

    mips_fact dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: job-level view (operand, factorial, edges remaining).
    logic [3:0]  m_n;
    logic        m_go, m_done, m_err;
    logic [31:0] m_result, m_pending;
    int          m_left;

    function automatic logic [31:0] fact(input int k);
        logic [31:0] p;
        p = 32'd1;
        for (int i = 2; i <= k; i++) p = p * i;
        return p;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] addr);
        case (addr)
            2'd0:    return {28'd0, m_n};
            2'd1:    return {31'd0, m_go};
            2'd2:    return {30'd0, m_err, m_done};
            default: return m_result;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_n = 0; m_go = 0; m_done = 0; m_err = 0;
            m_result = 0; m_pending = 0; m_left = 0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_result = m_pending;
                m_done   = 1;
                m_go     = 0;
            end
        end else begin
            if (we && a == 2'd0) m_n = wd[3:0];
            if (we && a == 2'd1 && wd[0]) begin
                if (m_n > 12) begin
                    m_err = 1; m_done = 1;
                end else begin
                    m_err = 0; m_done = 0; m_go = 1;
                    m_left    = (m_n == 0) ? 1 : int'(m_n);
                    m_pending = fact(int'(m_n));
                end
            end
        end
    end

    // Per-cycle comparison of whatever register is currently addressed.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (rd !== exp_rd(a)) begin
                errors++;
                $display("FAIL cycle_rd t=%0t a=%0d actual=%h required=%h", $time, a, rd, exp_rd(a));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] addr, input logic [31:0] data);
        we = 1'b1; a = addr; wd = data;
        step();
        $display("write a=%0d wd=%h", addr, data);
        we = 1'b0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) begin
            we = 1'b0; a = rot; wd = $urandom;
            rot = rot + 2'd1;
            step();
        end
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [31:0] val);
        we = 1'b0; a = addr;
        #1;
        checks++;
        if (rd !== val) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, rd, val);
        end else begin
            $display("read %s a=%0d rd=%h", name, addr, rd);
        end
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; a = 2'd0; wd = 32'd0;
        step();
        chk_en = 1;
        step();
        check_reg("reset_n", 2'd0, 32'd0);
        check_reg("reset_go", 2'd1, 32'd0);
        check_reg("reset_status", 2'd2, 32'd0);
        check_reg("reset_result", 2'd3, 32'd0);
        rst_n = 1'b1;

        // Basic job N=5
        write(2'd0, 32'd5);
        write(2'd1, 32'd1);
        check_reg("n5_go_busy", 2'd1, 32'd1);
        check_reg("n5_status_e1", 2'd2, 32'd0);
        idle(4);
        check_reg("n5_status_e5", 2'd2, 32'd0);
        idle(1);
        check_reg("n5_status_e6", 2'd2, 32'd1);
        check_reg("n5_result", 2'd3, 32'h0000_0078);

        // Overflow operand
        write(2'd0, 32'd13);
        write(2'd1, 32'd1);
        check_reg("n13_status", 2'd2, 32'd3);
        check_reg("n13_result_kept", 2'd3, 32'h0000_0078);
        check_reg("n13_go", 2'd1, 32'd0);
        check_reg("n13_n", 2'd0, 32'd13);

        // Largest legal operand
        write(2'd0, 32'd12);
        write(2'd1, 32'd1);
        check_reg("n12_status_clr", 2'd2, 32'd0);
        idle(11);
        check_reg("n12_status_e12", 2'd2, 32'd0);
        idle(1);
        check_reg("n12_result", 2'd3, 32'h1C8C_FC00);
        check_reg("n12_status", 2'd2, 32'd1);

        // Degenerate operands
        write(2'd0, 32'd0);
        write(2'd1, 32'd1);
        check_reg("n0_status_e1", 2'd2, 32'd0);
        idle(1);
        check_reg("n0_result", 2'd3, 32'd1);
        write(2'd0, 32'd1);
        write(2'd1, 32'hFFFF_FFFF);
        idle(1);
        check_reg("n1_result", 2'd3, 32'd1);
        check_reg("n1_status", 2'd2, 32'd1);

        // Writes during BUSY are ignored
        write(2'd0, 32'd6);
        write(2'd1, 32'd1);
        idle(1);
        write(2'd0, 32'd2);
        write(2'd1, 32'd1);
        idle(2);
        check_reg("busy_status_e6", 2'd2, 32'd0);
        idle(1);
        check_reg("busy_result", 2'd3, 32'h0000_02D0);
        check_reg("busy_n_kept", 2'd0, 32'd6);

        // Read-only registers, GO with bit0 clear, we=0 never writes
        write(2'd3, 32'hDEAD_BEEF);
        write(2'd2, 32'hFFFF_FFFF);
        write(2'd1, 32'h0000_0002);
        check_reg("ro_result", 2'd3, 32'h0000_02D0);
        check_reg("ro_status", 2'd2, 32'd1);
        check_reg("go_bit0_clr", 2'd1, 32'd0);
        we = 1'b0; a = 2'd0; wd = 32'd9;
        step();
        check_reg("we0_n", 2'd0, 32'd6);

        // Reset mid-job, with a simultaneous write that must lose
        write(2'd0, 32'd10);
        write(2'd1, 32'd1);
        idle(2);
        rst_n = 1'b0; we = 1'b1; a = 2'd0; wd = 32'd7;
        step();
        rst_n = 1'b1; we = 1'b0;
        check_reg("rst_n", 2'd0, 32'd0);
        check_reg("rst_go", 2'd1, 32'd0);
        check_reg("rst_status", 2'd2, 32'd0);
        check_reg("rst_result", 2'd3, 32'd0);
        write(2'd0, 32'd3);
        write(2'd1, 32'd1);
        idle(2);
        check_reg("n3_status_e3", 2'd2, 32'd0);
        idle(1);
        check_reg("n3_result", 2'd3, 32'd6);
        idle(4);

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_fact.md
MIPS_FACT -- requirements
Module: mips_fact

Interface
REQ-001 The block SHALL be a memory-mapped factorial accelerator that sits downstream of the SoC address decoder and is selected by that decoder's peripheral write-enable.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on clk rising edge.
REQ-005 we  input  1  peripheral write enable, driven by the decoder's peripheral write-enable output.
REQ-006 a  input  2  word select, connected to bus address bits [3:2]; other address bits SHALL be ignored.
REQ-007 wd  input  32  write data.
REQ-008 rd  output  32  read data, combinational from a and register state.

Function
REQ-009 Register map SHALL be: a=0 N (rd = {28'b0, n[3:0]}); a=1 GO (rd = {31'b0, go}); a=2 STATUS (rd = {30'b0, err, done}); a=3 RESULT (rd = result[31:0]).
REQ-010 States SHALL be IDLE and BUSY only.
REQ-011 A write with a=0 in IDLE SHALL load n <= wd[3:0]; a=0 writes in BUSY SHALL be ignored.
REQ-012 A write with a=1 and wd[0]=1 in IDLE SHALL start a job: cnt <= n, prod <= 1, done <= 0, err <= 0.
REQ-013 If the started job has n > 12, the block SHALL set err=1 and done=1 on that same edge, stay in IDLE, and leave result unchanged.
REQ-014 If the started job has n <= 12, the block SHALL enter BUSY on that edge with go=1.
REQ-015 Writes with a=1 and wd[0]=0, and any a=1 write in BUSY, SHALL be ignored.
REQ-016 In BUSY with cnt > 1, each edge SHALL update prod <= prod*cnt (32-bit, no overflow possible for n <= 12) and cnt <= cnt-1.
REQ-017 In BUSY with cnt <= 1, the next edge SHALL update result <= prod, done <= 1, go <= 0, and state <= IDLE.
REQ-018 Latency SHALL be fixed: counting the go-write edge as edge 1, done and result become visible after edge max(n,1)+1.
REQ-019 Writes to a=2 or a=3 SHALL be ignored, because STATUS and RESULT are read-only.
REQ-020 done and err SHALL hold until the next accepted start or reset.
REQ-021 result SHALL hold its last value until a later successful completion overwrites it.
REQ-022 rd SHALL reflect state updated on the most recent edge (no read latency).
REQ-023 we=0 SHALL never alter N or GO.

Reset
REQ-024 rst_n=0 at a clk edge SHALL force state=IDLE, n=0, go=0, done=0, err=0, cnt=0, prod=1, and result=0.
REQ-025 Reset asserted during BUSY SHALL abort the job with no result update.
REQ-026 Reset SHALL take priority over any simultaneous write.
REQ-027 The first write SHALL be accepted on the edge after rst_n returns to 1.

Verification
REQ-028 Basic job: write N=5, then GO=1 -> STATUS reads 0 for 5 edges after the go edge, then STATUS=0x1 and RESULT=0x00000078 at edge 6.
REQ-029 Largest legal operand: N=12, GO=1 -> RESULT=0x1C8CFC00 and done=1 after edge 13; err=0.
REQ-030 Overflow operand: RESULT=0x78 from a prior job, then N=13 and GO=1 -> STATUS=0x3 on the go edge, RESULT stays 0x78, and GO reads 0.
REQ-031 Degenerate operands: N=0 -> RESULT=1 after edge 2; N=1 -> RESULT=1 after edge 2.
REQ-032 Writes during BUSY: start N=6, then at edge 3 write N=2 and GO=1 -> both are ignored; RESULT=0x2D0 (720) after edge 7; N still reads 6.
REQ-033 Reset mid-job: start N=10, assert rst_n=0 at edge 4 -> all reads return 0 next cycle; a subsequent N=3, GO=1 yields RESULT=6 after edge 4.
